// File: rtl/cosim_chan_sched.sv
// Round-robin scheduler that serialises N requesters onto one export/import
// co-simulation channel, one outstanding transaction at a time.
module cosim_chan_sched #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int IDW     = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_err,
  output logic            exp_valid,
  input  logic            exp_ready,
  output logic [DW-1:0]   exp_data,
  output logic [IDW-1:0]  exp_id,
  input  logic            imp_valid,
  input  logic [DW-1:0]   imp_data,
  input  logic [IDW-1:0]  imp_id,
  output logic            busy,
  output logic [7:0]      stray_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPORT,
    S_WAIT_IMP,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gnt;
  logic [DW-1:0]  r_data;
  logic [DW-1:0]  r_rsp_data;
  logic           r_rsp_err;
  logic [31:0]    r_timer;
  logic [7:0]     r_stray;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic           w_any;
  logic [IDW-1:0] w_first;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_match;

  // Rotate the request vector so bit 0 is the requester just after the last grant.
  assign w_dbl = {req_valid, req_valid};
  assign w_rot = N'(w_dbl >> (r_ptr + 1'b1));

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_any   = 1'b0;
    w_first = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any   = 1'b1;
        w_first = IDW'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_first} + 1'b1;
    if (w_sum >= (IDW + 1)'(N)) w_sum = w_sum - (IDW + 1)'(N);
    w_idx = w_sum[IDW-1:0];
  end

  assign w_match = (r_state == S_WAIT_IMP) && imp_valid && (imp_id == r_gnt);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IDW'(N - 1);
      r_gnt      <= '0;
      r_data     <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_timer    <= '0;
      r_stray    <= '0;
    end else begin
      // Any import not matching the live transaction is dropped and counted.
      if (imp_valid && !w_match && (r_stray != 8'hFF)) r_stray <= r_stray + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_idx;
            r_data  <= req_data[w_idx*DW +: DW];
            r_state <= S_EXPORT;
          end
        end
        S_EXPORT: begin
          if (exp_ready) begin
            r_timer <= '0;
            r_state <= S_WAIT_IMP;
          end
        end
        S_WAIT_IMP: begin
          r_timer <= r_timer + 32'd1;
          if (w_match) begin
            r_rsp_data <= imp_data;
            r_rsp_err  <= 1'b0;
            r_state    <= S_RESP;
          end else if ((TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1))) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          r_ptr   <= r_gnt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = ((r_state == S_IDLE) && w_any) ? (N'(1) << w_idx) : '0;
  assign rsp_valid = (r_state == S_RESP) ? (N'(1) << r_gnt) : '0;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign exp_valid = (r_state == S_EXPORT);
  assign exp_data  = r_data;
  assign exp_id    = r_gnt;
  assign busy      = (r_state != S_IDLE);
  assign stray_cnt = r_stray;

endmodule

// File: tb/tb_cosim_chan_sched.sv
// Directed bench for cosim_chan_sched: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_cosim_chan_sched;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int IDW     = 4;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            exp_valid;
  logic            exp_ready;
  logic [DW-1:0]   exp_data;
  logic [IDW-1:0]  exp_id;
  logic            imp_valid;
  logic [DW-1:0]   imp_data;
  logic [IDW-1:0]  imp_id;
  logic            busy;
  logic [7:0]      stray_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cosim_chan_sched #(.N(N), .DW(DW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .exp_valid (exp_valid),
    .exp_ready (exp_ready),
    .exp_data  (exp_data),
    .exp_id    (exp_id),
    .imp_valid (imp_valid),
    .imp_data  (imp_data),
    .imp_id    (imp_id),
    .busy      (busy),
    .stray_cnt (stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    imp_valid = 1'b0;
    exp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle (falling edge + 1) with req_valid already driven.
  // Holds exp_ready low for bp EXPORT cycles, replies in the first WAIT_IMP cycle.
  task automatic serve(input string tag, input int g, input logic [DW-1:0] d,
                       input logic [DW-1:0] reply, input int bp);
    check({tag, "_grant"}, req_ready, oh(g));
    exp_ready = (bp == 0);
    @(negedge clk); #1;
    check({tag, "_exp_valid"}, exp_valid, 1'b1);
    check({tag, "_exp_data"}, exp_data, d);
    check({tag, "_exp_id"}, exp_id, g);
    check({tag, "_ready_pulse"}, req_ready, '0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (i == bp - 1) exp_ready = 1'b1;
      #1;
      check({tag, "_bp_valid"}, exp_valid, 1'b1);
      check({tag, "_bp_data"}, exp_data, d);
      check({tag, "_bp_id"}, exp_id, g);
      check({tag, "_bp_no_rsp"}, rsp_valid, '0);
    end
    @(negedge clk);
    imp_valid = 1'b1;
    imp_id    = IDW'(g);
    imp_data  = reply;
    #1;
    check({tag, "_wait_busy"}, busy, 1'b1);
    check({tag, "_wait_no_rsp"}, rsp_valid, '0);
    @(negedge clk);
    imp_valid = 1'b0;
    #1;
    check({tag, "_rsp_valid"}, rsp_valid, oh(g));
    check({tag, "_rsp_data"}, rsp_data, reply);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    @(negedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    exp_ready = 1'b0;
    imp_valid = 1'b0;
    imp_data  = '0;
    imp_id    = '0;

    do_reset();
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_exp_valid", exp_valid, 1'b0);
    check("rst_exp_data", exp_data, '0);
    check("rst_exp_id", exp_id, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_stray", stray_cnt, 8'd0);

    // Single request: response 3 cycles after the grant cycle.
    req_data[0 +: DW] = 32'hFAFA_FAFA;
    req_valid = 4'b0001;
    #1;
    serve("single", 0, 32'hFAFA_FAFA, 32'h1, 0);
    req_valid = '0;

    // Round-robin from reset with everyone requesting.
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'hC0DE_0000 + 32'(i);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++)
      serve($sformatf("rr%0d", k), k % N, 32'hC0DE_0000 + 32'(k % N), 32'h100 + 32'(k), 0);
    req_valid = '0;

    // Backpressure on the export side.
    req_valid = 4'b0010;
    #1;
    serve("bp", 1, 32'hC0DE_0001, 32'h2222, 5);
    req_valid = '0;

    // Stray import then matching import.
    req_valid = 4'b0100;
    #1;
    check("stray_grant", req_ready, 4'b0100);
    exp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    #1;
    check("stray_exp_id", exp_id, 2);
    @(negedge clk);
    imp_valid = 1'b1; imp_id = 4'd1; imp_data = 32'hCD;
    #1;
    @(negedge clk);
    imp_valid = 1'b1; imp_id = 4'd2; imp_data = 32'hAB;
    #1;
    check("stray_no_rsp", rsp_valid, '0);
    check("stray_cnt_1", stray_cnt, 8'd1);
    @(negedge clk);
    imp_valid = 1'b0;
    #1;
    check("stray_rsp_valid", rsp_valid, 4'b0100);
    check("stray_rsp_data", rsp_data, 32'hAB);
    check("stray_rsp_err", rsp_err, 1'b0);
    @(negedge clk); #1;

    // Timeout; an import on the handshake cycle itself is a stray.
    req_valid = 4'b1000;
    #1;
    check("to_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    imp_valid = 1'b1; imp_id = 4'd3; imp_data = 32'h55;
    #1;
    check("to_exp_id", exp_id, 3);
    @(negedge clk);
    imp_valid = 1'b0;
    #1;
    n = 0;
    while (rsp_valid == '0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("to_latency", n, 8);
    check("to_rsp_valid", rsp_valid, 4'b1000);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_data", rsp_data, '0);
    check("to_stray_cnt", stray_cnt, 8'd2);
    req_valid = 4'b1001;
    @(negedge clk); #1;
    serve("to_next", 0, 32'hC0DE_0000, 32'h77, 0);
    req_valid = '0;

    // Reset during WAIT_IMP aborts the transaction and restarts arbitration.
    req_valid = 4'b0110;
    #1;
    check("mr_grant", req_ready, 4'b0010);
    exp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mr_wait_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_no_rsp", rsp_valid, '0);
    check("mr_busy", busy, 1'b0);
    check("mr_stray", stray_cnt, 8'd0);
    check("mr_exp_valid", exp_valid, 1'b0);
    req_valid = 4'b1111;
    #1;
    check("mr_next_grant", req_ready, 4'b0001);
    @(negedge clk); #1;
    check("mr_next_exp_id", exp_id, 0);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
